// File: rtl/vectored_interrupt_controller.sv
// Vectored interrupt controller.
// Sits between the PC-next logic and the PC register. Accepts one of N_SRC
// level- or edge-triggered sources (lowest index wins), redirects fetch to the
// source's vector, and saves the interrupted PC into RET_REG. A JALR through
// RET_REG ends the handler. All state updates happen on the falling clock edge.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | normal fetch, waiting for an eligible request
//   S_ENTRY | one cycle: PC redirected to vector, interrupted PC saved
//   S_ISR   | handler running, no nesting, waiting for JALR through RET_REG
module vectored_interrupt_controller #(
    parameter int                N_SRC         = 4,
    parameter int                PC_WIDTH      = 32,
    parameter int                VECTOR_BASE   = 20,
    parameter int                VECTOR_STRIDE = 4,
    parameter int                RET_REG       = 30,
    parameter logic [N_SRC-1:0]  EDGE_MASK     = {N_SRC{1'b0}},
    localparam int               ID_WIDTH      = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_SRC-1:0]     irq_in,
    input  logic [N_SRC-1:0]     irq_enable,
    input  logic                 global_enable,
    input  logic [PC_WIDTH-1:0]  pc_next,
    input  logic                 jalr_select_signal,
    input  logic [4:0]           regfile_addr_1,
    output logic [PC_WIDTH-1:0]  pc_next_final,
    output logic [PC_WIDTH-1:0]  pc_next_regfile,
    output logic                 en_regfile,
    output logic [4:0]           regfile_waddr,
    output logic [N_SRC-1:0]     irq_ack,
    output logic                 in_isr,
    output logic [ID_WIDTH-1:0]  active_id,
    output logic [N_SRC-1:0]     pending
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ENTRY = 2'd1,
        S_ISR   = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [N_SRC-1:0]      edge_pend;
    logic [N_SRC-1:0]      prev_irq;
    logic [N_SRC-1:0]      eligible;
    logic [N_SRC-1:0]      edge_clr;
    logic [ID_WIDTH-1:0]   winner;
    logic                  return_hit;
    logic [PC_WIDTH-1:0]   vector_addr;

    assign regfile_waddr   = 5'(RET_REG);
    assign pc_next_regfile = pc_next;
    assign in_isr          = (state == S_ENTRY) || (state == S_ISR);
    assign return_hit      = jalr_select_signal && (regfile_addr_1 == 5'(RET_REG));
    assign vector_addr     = PC_WIDTH'(VECTOR_BASE)
                           + PC_WIDTH'(active_id) * PC_WIDTH'(VECTOR_STRIDE);

    // Edge sources read their latched flag; level sources read the line directly.
    always_comb begin
        pending  = (EDGE_MASK & edge_pend) | (~EDGE_MASK & irq_in);
        eligible = pending & irq_enable & {N_SRC{global_enable}};
    end

    // Fixed priority: scan downwards so the lowest eligible index is left last.
    always_comb begin
        winner = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = ID_WIDTH'(i);
            end
        end
    end

    // The serviced source's edge flag is consumed on leaving ENTRY.
    always_comb begin
        edge_clr = '0;
        if (state == S_ENTRY) begin
            edge_clr = N_SRC'(1) << active_id;
        end
    end

    // Next-state and output decode; IDLE and ISR are pass-through.
    always_comb begin
        state_next    = state;
        pc_next_final = pc_next;
        en_regfile    = 1'b0;
        irq_ack       = '0;
        case (state)
            S_IDLE: begin
                if (|eligible) begin
                    state_next = S_ENTRY;
                end
            end
            S_ENTRY: begin
                state_next    = S_ISR;
                pc_next_final = vector_addr;
                en_regfile    = 1'b1;
                irq_ack       = N_SRC'(1) << active_id;
            end
            S_ISR: begin
                if (return_hit) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State register; the winner is captured only when leaving IDLE.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            active_id <= '0;
        end else begin
            state <= state_next;
            if ((state == S_IDLE) && (|eligible)) begin
                active_id <= winner;
            end
        end
    end

    // Rising-edge detection; a new edge beats a simultaneous clear.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            prev_irq  <= '0;
            edge_pend <= '0;
        end else begin
            prev_irq  <= irq_in;
            edge_pend <= (edge_pend & ~edge_clr) | (irq_in & ~prev_irq);
        end
    end

endmodule

// File: tb/tb_vectored_interrupt_controller.sv
// Bench for vectored_interrupt_controller: five sources, 0..3 rising-edge,
// source 4 level. A behavioural model tracks the controller mode and the
// latched edge requests; directed scenarios plus a randomized run.
module tb_vectored_interrupt_controller;

    localparam int N   = 5;
    localparam int IDW = 3;
    localparam int BW  = 32 + 32 + 1 + 5 + N + 1 + IDW + N;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    irq_in;
    logic [N-1:0]    irq_enable;
    logic            global_enable;
    logic [31:0]     pc_next;
    logic            jalr;
    logic [4:0]      rs1;
    logic [31:0]     pc_next_final;
    logic [31:0]     pc_next_regfile;
    logic            en_regfile;
    logic [4:0]      regfile_waddr;
    logic [N-1:0]    irq_ack;
    logic            in_isr;
    logic [IDW-1:0]  active_id;
    logic [N-1:0]    pending;

    vectored_interrupt_controller #(
        .N_SRC     (N),
        .EDGE_MASK (5'b01111)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .irq_in             (irq_in),
        .irq_enable         (irq_enable),
        .global_enable      (global_enable),
        .pc_next            (pc_next),
        .jalr_select_signal (jalr),
        .regfile_addr_1     (rs1),
        .pc_next_final      (pc_next_final),
        .pc_next_regfile    (pc_next_regfile),
        .en_regfile         (en_regfile),
        .regfile_waddr      (regfile_waddr),
        .irq_ack            (irq_ack),
        .in_isr             (in_isr),
        .active_id          (active_id),
        .pending            (pending)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: mode 0 = running normally, 1 = taking the vector, 2 = in handler.
    int  m_mode;
    int  m_id;
    bit  m_latch [N];
    bit  m_prev  [N];
    logic [BW-1:0] exp_b;

    function automatic bit is_edge(int i);
        return i < 4;
    endfunction

    function automatic logic [N-1:0] model_pending();
        logic [N-1:0] p;
        for (int i = 0; i < N; i++) p[i] = is_edge(i) ? m_latch[i] : irq_in[i];
        return p;
    endfunction

    function automatic logic [BW-1:0] exp_bundle();
        logic [31:0]  pcf;
        logic         en;
        logic [N-1:0] ack;
        pcf = pc_next;
        en  = 1'b0;
        ack = '0;
        if (m_mode == 1) begin
            pcf      = 32'(20 + 4 * m_id);
            en       = 1'b1;
            ack[m_id] = 1'b1;
        end
        return {pcf, pc_next, en, 5'd30, ack, 1'(m_mode != 0), IDW'(m_id), model_pending()};
    endfunction

    function automatic logic [BW-1:0] dut_b();
        return {pc_next_final, pc_next_regfile, en_regfile, regfile_waddr,
                irq_ack, in_isr, active_id, pending};
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_id   = 0;
        for (int i = 0; i < N; i++) begin
            m_latch[i] = 1'b0;
            m_prev[i]  = 1'b0;
        end
    endtask

    task automatic model_step();
        logic [N-1:0] elig;
        bit found;
        elig  = model_pending() & irq_enable & {N{global_enable}};
        found = 1'b0;
        if (m_mode == 0) begin
            for (int i = 0; i < N; i++) begin
                if (elig[i] && !found) begin
                    m_id  = i;
                    found = 1'b1;
                end
            end
            if (found) m_mode = 1;
        end else if (m_mode == 1) begin
            m_latch[m_id] = 1'b0;
            m_mode = 2;
        end else if (jalr && rs1 == 5'd30) begin
            m_mode = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (irq_in[i] && !m_prev[i]) m_latch[i] = 1'b1;
            m_prev[i] = irq_in[i];
        end
    endtask

    task automatic cyc_begin();
        @(posedge clk);
        jalr = 1'b0;
        rs1  = 5'd0;
    endtask

    task automatic cyc_settle();
        #1;
        exp_b = exp_bundle();
    endtask

    task automatic cyc_end();
        @(negedge clk);
        model_step();
    endtask

    task automatic apply_reset();
        @(posedge clk);
        reset = 1'b1;
        irq_in = '0;
        irq_enable = '1;
        global_enable = 1'b1;
        jalr = 1'b0;
        rs1 = 5'd0;
        #1;
        model_reset();
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        model_step();
    endtask

    task automatic test_reset();
        @(posedge clk);
        reset = 1'b1;
        irq_in = '0;
        irq_enable = '1;
        global_enable = 1'b1;
        pc_next = 32'h0000_0040;
        #1;
        model_reset();
        exp_b = exp_bundle();
        tests++;
        if (dut_b() !== exp_b) begin
            fails++;
            $display("FAIL reset_asserted got=%h exp=%h", dut_b(), exp_b);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        model_step();
        for (int c = 0; c < 5; c++) begin
            cyc_begin();
            pc_next = $urandom;
            cyc_settle();
            tests++;
            if (dut_b() !== exp_b) begin
                fails++;
                $display("FAIL reset_idle c%0d got=%h exp=%h", c, dut_b(), exp_b);
            end
            tests++;
            if (pc_next_final !== pc_next || en_regfile !== 1'b0 || irq_ack !== 5'b0 || in_isr !== 1'b0) begin
                fails++;
                $display("FAIL reset_passthru c%0d pcf=%h pc=%h en=%b ack=%b isr=%b", c,
                         pc_next_final, pc_next, en_regfile, irq_ack, in_isr);
            end
            cyc_end();
        end
    endtask

    task automatic test_edge_entry();
        apply_reset();
        pc_next = 32'h100;
        for (int c = 0; c < 6; c++) begin
            cyc_begin();
            if (c == 0) irq_in[2] = 1'b1;
            if (c == 4) begin jalr = 1'b1; rs1 = 5'd30; end
            if (c == 5) irq_in[2] = 1'b0;
            cyc_settle();
            tests++;
            if (dut_b() !== exp_b) begin
                fails++;
                $display("FAIL edge_entry c%0d got=%h exp=%h", c, dut_b(), exp_b);
            end
            if (c == 1) begin
                tests++;
                if (pending[2] !== 1'b1 || in_isr !== 1'b0) begin
                    fails++;
                    $display("FAIL edge_latency pending=%b isr=%b, need pending[2]=1 isr=0", pending, in_isr);
                end
            end
            if (c == 2) begin
                tests++;
                if (pc_next_final !== 32'd28 || en_regfile !== 1'b1 || pc_next_regfile !== 32'h100 || irq_ack !== 5'b00100) begin
                    fails++;
                    $display("FAIL edge_vector pcf=%0d en=%b save=%h ack=%b, need 28 1 100 00100",
                             pc_next_final, en_regfile, pc_next_regfile, irq_ack);
                end
            end
            if (c == 3) begin
                tests++;
                if (in_isr !== 1'b1 || pending[2] !== 1'b0 || en_regfile !== 1'b0) begin
                    fails++;
                    $display("FAIL edge_isr isr=%b pending=%b en=%b, need 1 xx0xx 0", in_isr, pending, en_regfile);
                end
            end
            if (c == 5) begin
                tests++;
                if (in_isr !== 1'b0) begin
                    fails++;
                    $display("FAIL edge_return isr=%b need 0", in_isr);
                end
            end
            cyc_end();
        end
    endtask

    task automatic test_priority();
        apply_reset();
        for (int c = 0; c < 9; c++) begin
            cyc_begin();
            pc_next = 32'h200 + 32'(4 * c);
            if (c == 0) begin irq_in[1] = 1'b1; irq_in[3] = 1'b1; end
            if (c == 2) begin irq_in[1] = 1'b0; irq_in[3] = 1'b0; end
            if (c == 3 || c == 7) begin jalr = 1'b1; rs1 = 5'd30; end
            if (c == 6) begin jalr = 1'b1; rs1 = 5'd5; end
            cyc_settle();
            tests++;
            if (dut_b() !== exp_b) begin
                fails++;
                $display("FAIL priority c%0d got=%h exp=%h", c, dut_b(), exp_b);
            end
            if (c == 2) begin
                tests++;
                if (pc_next_final !== 32'd24 || active_id !== 3'd1) begin
                    fails++;
                    $display("FAIL priority_first pcf=%0d id=%0d, need 24 1", pc_next_final, active_id);
                end
            end
            if (c == 4) begin
                tests++;
                if (in_isr !== 1'b0 || pending !== 5'b01000) begin
                    fails++;
                    $display("FAIL priority_gap isr=%b pending=%b, need 0 01000", in_isr, pending);
                end
            end
            if (c == 5) begin
                tests++;
                if (pc_next_final !== 32'd32 || irq_ack !== 5'b01000) begin
                    fails++;
                    $display("FAIL priority_second pcf=%0d ack=%b, need 32 01000", pc_next_final, irq_ack);
                end
            end
            if (c == 7) begin
                tests++;
                if (in_isr !== 1'b1) begin
                    fails++;
                    $display("FAIL jalr_other_reg isr=%b need 1", in_isr);
                end
            end
            if (c == 8) begin
                tests++;
                if (in_isr !== 1'b0) begin
                    fails++;
                    $display("FAIL jalr_ret_reg isr=%b need 0", in_isr);
                end
            end
            cyc_end();
        end
    endtask

    task automatic test_masking();
        apply_reset();
        for (int c = 0; c < 9; c++) begin
            cyc_begin();
            pc_next = 32'h300 + 32'(4 * c);
            if (c == 0) begin irq_enable = 5'b11110; irq_in[0] = 1'b1; end
            if (c == 1) irq_in[0] = 1'b0;
            if (c == 5) irq_enable = 5'b11111;
            if (c == 7) begin jalr = 1'b1; rs1 = 5'd30; end
            cyc_settle();
            tests++;
            if (dut_b() !== exp_b) begin
                fails++;
                $display("FAIL mask c%0d got=%h exp=%h", c, dut_b(), exp_b);
            end
            if (c == 4) begin
                tests++;
                if (pending[0] !== 1'b1 || in_isr !== 1'b0) begin
                    fails++;
                    $display("FAIL mask_hold pending=%b isr=%b, need xxxx1 0", pending, in_isr);
                end
            end
            if (c == 6) begin
                tests++;
                if (pc_next_final !== 32'd20 || irq_ack !== 5'b00001) begin
                    fails++;
                    $display("FAIL mask_release pcf=%0d ack=%b, need 20 00001", pc_next_final, irq_ack);
                end
            end
            cyc_end();
        end
        for (int c = 0; c < 13; c++) begin
            cyc_begin();
            pc_next = 32'h400 + 32'(4 * c);
            if (c == 0) begin global_enable = 1'b0; irq_in[4] = 1'b1; irq_in[2] = 1'b1; end
            if (c == 1) irq_in[2] = 1'b0;
            if (c == 5) global_enable = 1'b1;
            if (c == 7) begin jalr = 1'b1; rs1 = 5'd30; end
            if (c == 10) begin irq_in[4] = 1'b0; jalr = 1'b1; rs1 = 5'd30; end
            cyc_settle();
            tests++;
            if (dut_b() !== exp_b) begin
                fails++;
                $display("FAIL global c%0d got=%h exp=%h", c, dut_b(), exp_b);
            end
            if (c == 4) begin
                tests++;
                if (in_isr !== 1'b0 || pending !== 5'b10100) begin
                    fails++;
                    $display("FAIL global_block isr=%b pending=%b, need 0 10100", in_isr, pending);
                end
            end
            if (c == 6) begin
                tests++;
                if (pc_next_final !== 32'd28) begin
                    fails++;
                    $display("FAIL global_release pcf=%0d need 28", pc_next_final);
                end
            end
            if (c == 9) begin
                tests++;
                if (pc_next_final !== 32'd36 || irq_ack !== 5'b10000) begin
                    fails++;
                    $display("FAIL level_entry pcf=%0d ack=%b, need 36 10000", pc_next_final, irq_ack);
                end
            end
            if (c == 12) begin
                tests++;
                if (in_isr !== 1'b0 || pending !== 5'b00000) begin
                    fails++;
                    $display("FAIL level_cleared isr=%b pending=%b, need 0 00000", in_isr, pending);
                end
            end
            cyc_end();
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int c = 0; c < 10; c++) begin
            cyc_begin();
            pc_next = 32'h500 + 32'(4 * c);
            if (c == 0) irq_in[2] = 1'b1;
            if (c == 4) irq_in = '0;
            if (c == 5) irq_in[1] = 1'b1;
            cyc_settle();
            tests++;
            if (dut_b() !== exp_b) begin
                fails++;
                $display("FAIL async_rst c%0d got=%h exp=%h", c, dut_b(), exp_b);
            end
            if (c == 4) begin
                #1 reset = 1'b1;
                #1;
                model_reset();
                exp_b = exp_bundle();
                tests++;
                if (in_isr !== 1'b0 || pending !== 5'b0 || pc_next_final !== pc_next || en_regfile !== 1'b0) begin
                    fails++;
                    $display("FAIL async_rst_drop isr=%b pending=%b pcf=%h pc=%h, need 0 00000 pcf=pc",
                             in_isr, pending, pc_next_final, pc_next);
                end
                tests++;
                if (dut_b() !== exp_b) begin
                    fails++;
                    $display("FAIL async_rst_state got=%h exp=%h", dut_b(), exp_b);
                end
                #1 reset = 1'b0;
            end
            if (c == 7) begin
                tests++;
                if (pc_next_final !== 32'd24 || irq_ack !== 5'b00010) begin
                    fails++;
                    $display("FAIL async_rst_resume pcf=%0d ack=%b, need 24 00010", pc_next_final, irq_ack);
                end
            end
            cyc_end();
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            cyc_begin();
            pc_next = $urandom;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 5) == 0) irq_in[i] = ~irq_in[i];
            end
            irq_enable = ($urandom_range(0, 7) == 0) ? N'($urandom) : '1;
            global_enable = ($urandom_range(0, 9) != 0);
            jalr = ($urandom_range(0, 3) == 0);
            rs1  = ($urandom_range(0, 1) == 0) ? 5'd30 : 5'($urandom);
            cyc_settle();
            tests++;
            if (dut_b() !== exp_b) begin
                fails++;
                $display("FAIL random c%0d got=%h exp=%h", c, dut_b(), exp_b);
            end
            cyc_end();
        end
    endtask

    initial begin
        reset = 1'b0;
        irq_in = '0;
        irq_enable = '1;
        global_enable = 1'b1;
        pc_next = '0;
        jalr = 1'b0;
        rs1 = 5'd0;
        model_reset();
        test_reset();
        test_edge_entry();
        test_priority();
        test_masking();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog sim time exceeded, tests=%0d fails=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
